// File: rtl/sdram_pkg.sv
// Shared constants for the SDRAM traffic generator: pattern modes, FSM encoding, LFSR taps.
package sdram_pkg;
  localparam int PAT_INC  = 0;
  localparam int PAT_LFSR = 1;
  localparam int PAT_WALK = 2;

  // Galois form of x^16+x^14+x^13+x^11+1, shifting right
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_INIT, S_WR_BURST, S_WR_GAP, S_RD_BURST, S_RD_GAP, S_FIN
  } state_t;
endpackage

// File: rtl/sdram_traffic_gen_pattern_gen.sv
// Data pattern source shared by the write and read phases; reloaded from SEED on load.
module pattern_gen
  import sdram_pkg::*;
#(
  parameter int                DATA_W   = 16,
  parameter int                PAT_MODE = PAT_INC,
  parameter logic [DATA_W-1:0] SEED     = DATA_W'(1)
) (
  input  logic              clk_100m,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  output logic [DATA_W-1:0] pattern
);
  localparam logic [DATA_W-1:0] TAPS = DATA_W'(LFSR_TAPS);
  // an all-zero LFSR state would lock up
  localparam logic [DATA_W-1:0] SEED_EFF =
    (PAT_MODE == PAT_LFSR && SEED == '0) ? DATA_W'(1) : SEED;

  logic [DATA_W-1:0] nxt;

  always_comb begin
    nxt = pattern + DATA_W'(1);
    if (PAT_MODE == PAT_LFSR)      nxt = (pattern >> 1) ^ (pattern[0] ? TAPS : '0);
    else if (PAT_MODE == PAT_WALK) nxt = {pattern[DATA_W-2:0], pattern[DATA_W-1]};
  end

  always_ff @(posedge clk_100m or negedge rst_n)
    if (!rst_n)    pattern <= '0;
    else if (load) pattern <= SEED_EFF;
    else if (step) pattern <= nxt;
endmodule

// File: rtl/sdram_traffic_gen.sv
// Write-then-readback traffic generator for the sdram_ctrl user ports.
// Reports pass/done, a saturating mismatch count and the first failing address.
module sdram_traffic_gen
  import sdram_pkg::*;
#(
  parameter int                DATA_W     = 16,
  parameter int                ADDR_W     = 24,
  parameter int                LEN_W      = 10,
  parameter int                BURST_LEN  = 10,
  parameter int                NUM_BURSTS = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter int                PAT_MODE   = PAT_INC,
  parameter logic [DATA_W-1:0] SEED       = DATA_W'(1)
) (
  input  logic              clk_100m,
  input  logic              rst_n,
  input  logic              init_end,
  input  logic              start,
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [LEN_W-1:0]  wr_len,
  output logic [DATA_W-1:0] wr_data,
  input  logic              wr_ack,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [LEN_W-1:0]  rd_len,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              rd_ack,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_cnt,
  output logic [ADDR_W-1:0] first_err_addr
);
  localparam int BC_W = $clog2(NUM_BURSTS + 1);

  state_t            state;
  logic [LEN_W-1:0]  word_cnt;
  logic [BC_W-1:0]   burst_cnt;
  logic [ADDR_W-1:0] burst_addr;
  logic [DATA_W-1:0] pattern;
  logic start_ok, wr_hit, rd_hit, last_word, bursts_done, pat_load, rd_mismatch;

  assign wr_len      = LEN_W'(BURST_LEN);
  assign rd_len      = LEN_W'(BURST_LEN);
  assign wr_data     = pattern;
  assign start_ok    = (state == S_IDLE) && start;
  assign wr_hit      = (state == S_WR_BURST) && wr_ack;
  assign rd_hit      = (state == S_RD_BURST) && rd_ack;
  assign last_word   = (word_cnt == LEN_W'(BURST_LEN - 1));
  assign bursts_done = (burst_cnt == BC_W'(NUM_BURSTS));
  // reload at pass start and again as the read phase begins
  assign pat_load    = start_ok || ((state == S_WR_GAP) && init_end && bursts_done);
  assign rd_mismatch = rd_hit && (rd_data != pattern);

  pattern_gen #(.DATA_W(DATA_W), .PAT_MODE(PAT_MODE), .SEED(SEED)) u_pat (
    .clk_100m (clk_100m),
    .rst_n    (rst_n),
    .load     (pat_load),
    .step     (wr_hit || rd_hit),
    .pattern  (pattern)
  );

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      word_cnt       <= '0;
      burst_cnt      <= '0;
      burst_addr     <= '0;
      wr_req         <= 1'b0;
      wr_addr        <= '0;
      rd_req         <= 1'b0;
      rd_addr        <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_cnt        <= '0;
      first_err_addr <= '0;
    end else begin
      done <= 1'b0;
      if (rd_mismatch) begin
        if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
        if (err_cnt == '0)       first_err_addr <= rd_addr + ADDR_W'(word_cnt);
      end
      case (state)
        S_IDLE: if (start) begin
          state          <= S_WAIT_INIT;
          busy           <= 1'b1;
          pass           <= 1'b0;
          err_cnt        <= '0;
          first_err_addr <= '0;
          burst_cnt      <= '0;
          burst_addr     <= BASE_ADDR;
        end
        S_WAIT_INIT: if (init_end) begin
          state    <= S_WR_BURST;
          wr_req   <= 1'b1;
          wr_addr  <= burst_addr;
          word_cnt <= '0;
        end
        S_WR_BURST: if (wr_ack) begin
          word_cnt <= word_cnt + LEN_W'(1);
          if (last_word) begin
            state      <= S_WR_GAP;
            wr_req     <= 1'b0;
            burst_cnt  <= burst_cnt + BC_W'(1);
            burst_addr <= burst_addr + ADDR_W'(BURST_LEN);
          end
        end
        // gaps also hold here while init_end is low
        S_WR_GAP: if (init_end) begin
          word_cnt <= '0;
          if (bursts_done) begin
            state      <= S_RD_BURST;
            burst_cnt  <= '0;
            burst_addr <= BASE_ADDR;
            rd_addr    <= BASE_ADDR;
            rd_req     <= 1'b1;
          end else begin
            state   <= S_WR_BURST;
            wr_addr <= burst_addr;
            wr_req  <= 1'b1;
          end
        end
        S_RD_BURST: if (rd_ack) begin
          word_cnt <= word_cnt + LEN_W'(1);
          if (last_word) begin
            state      <= S_RD_GAP;
            rd_req     <= 1'b0;
            burst_cnt  <= burst_cnt + BC_W'(1);
            burst_addr <= burst_addr + ADDR_W'(BURST_LEN);
          end
        end
        S_RD_GAP:
          if (bursts_done) begin
            state <= S_FIN;
            done  <= 1'b1;
            busy  <= 1'b0;
            pass  <= (err_cnt == '0);
          end else if (init_end) begin
            state    <= S_RD_BURST;
            rd_addr  <= burst_addr;
            rd_req   <= 1'b1;
            word_cnt <= '0;
          end
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
